// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops len words from a registered-output FIFO wrapper and streams them out.
//   clk, rst_n          clock, async active-low reset
//   start, len          begin a burst of len words (accepted only in IDLE)
//   fifo_empty          wrapper empty flag, lags pops by one cycle
//   fifo_data           wrapper read data, valid two cycles after fifo_rden
//   fifo_rden           pop request to wrapper
//   out_data/valid/last valid/ready stream driven by the skid-buffer head
//   out_ready           consumer accept
//   busy, done          burst in progress / one-cycle completion pulse
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rden,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [LEN_W-1:0] len_q, issued, acc;
    logic [1:0] pipe, cnt, inflight;
    logic rden_q, wp, rp, wr, rd, last_acc, launch;
    logic [DATA_WIDTH-1:0] skid [2];
    assign inflight = {1'b0, pipe[0]} + {1'b0, pipe[1]};
    assign wr       = pipe[1];
    assign rd       = out_valid && out_ready;
    assign last_acc = rd && acc == len_q - 1'b1;
    assign launch   = state == IDLE && start && len != '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == IDLE && start) ? (len == '0 ? DONE : RUN) :
                    (state == RUN && last_acc) ? DONE :
                    (state == DONE) ? IDLE : state;
    end
    // rden_q blocks back-to-back pops: the lagged empty flag cannot yet show the previous pop
    always_comb begin
        fifo_rden = state == RUN && issued < len_q && !fifo_empty && !rden_q &&
                    ({1'b0, cnt} + {1'b0, inflight}) < 3'd2;
        busy      = state == RUN;
        done      = state == DONE;
        out_valid = cnt != 2'd0;
        out_last  = out_valid && acc == len_q - 1'b1;
        out_data  = skid[rp];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            issued  <= '0;
            acc     <= '0;
            pipe    <= '0;
            rden_q  <= 1'b0;
            wp      <= 1'b0;
            rp      <= 1'b0;
            cnt     <= '0;
            skid[0] <= '0;
            skid[1] <= '0;
        end else begin
            rden_q <= fifo_rden;
            pipe   <= {pipe[0], fifo_rden};
            if (launch) begin
                len_q  <= len;
                issued <= '0;
                acc    <= '0;
            end else begin
                if (fifo_rden) issued <= issued + 1'b1;
                if (rd)        acc    <= acc + 1'b1;
            end
            if (wr) begin
                skid[wp] <= fifo_data;
                wp       <= ~wp;
            end
            if (rd) rp <= ~rp;
            cnt <= cnt + {1'b0, wr} - {1'b0, rd};
            if (wr) assert (cnt != 2'd2);
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed and randomized bursts checked against a word-queue reference model.
module tb_fifo_burst_reader;
    logic clk = 1'b0, rst_n, start, fifo_empty, fifo_rden, out_valid, out_last, out_ready, busy, done;
    logic [7:0] len, fifo_data, out_data, d1;
    logic [7:0] fq[$], exp_q[$];
    int pass_n = 0, total_n = 0, pops = 0, accepts = 0, lasts = 0, cyc = 0, last_pop = -1;
    int len_m = 0, acc_m = 0;
    bit m_busy = 0, m_done = 0, chk_gap = 0, prev_stall = 0;
    logic [7:0] prev_data;
    always #5 clk = ~clk;
    fifo_burst_reader #(.DATA_WIDTH(8), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rden(fifo_rden), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done)
    );
    // Wrapper model: two-cycle registered read data, empty flag registered from pre-pop occupancy
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= '0;
            fifo_data <= '0;
            fifo_empty <= 1'b1;
        end else begin
            fifo_empty <= (fq.size() == 0);
            fifo_data <= d1;
            if (fifo_rden && fq.size() > 0) d1 <= fq.pop_front();
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_n++;
        assert (obs === exp_v) pass_n++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask
    task automatic push(input logic [7:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask
    task automatic check_reset();
        chk("rst_rden", fifo_rden, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask
    task automatic tick();
        bit nb, nd;
        #1;
        cyc++;
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("last", out_last, out_valid && m_busy && acc_m == len_m - 1);
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
        end
        if (fifo_rden) begin
            pops++;
            chk("pop_empty", fifo_empty, 0);
            if (chk_gap && last_pop >= 0) chk("pop_gap", cyc - last_pop, 2);
            last_pop = cyc;
        end
        nb = m_busy;
        nd = 0;
        if (out_valid && out_ready) begin
            accepts++;
            if (out_last) lasts++;
            if (exp_q.size() == 0) chk("spurious_word", out_valid, 0);
            else begin
                chk("data", out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (m_busy && acc_m == len_m - 1) begin
                nb = 0;
                nd = 1;
            end
            acc_m++;
        end
        if (start && !m_busy && !m_done) begin
            if (len == 0) nd = 1;
            else begin
                nb = 1;
                len_m = len;
                acc_m = 0;
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
        m_busy = nb;
        m_done = nd;
        @(negedge clk);
    endtask
    task automatic launch(input logic [7:0] l);
        start = 1;
        len = l;
        tick();
        start = 0;
    endtask
    task automatic run_idle(input int max, input bit rnd, input bit feed);
        int n = 0;
        while ((m_busy || m_done) && n < max) begin
            if (feed && fq.size() < 3) push(8'($urandom));
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("timeout", m_busy || m_done, 0);
    endtask
    task automatic clear_counts();
        pops = 0;
        accepts = 0;
        lasts = 0;
        last_pop = -1;
    endtask
    initial begin
        rst_n = 0;
        start = 0;
        len = 0;
        out_ready = 0;
        @(negedge clk);
        #1 check_reset();
        @(negedge clk);
        rst_n = 1;
        // 1: zero-length burst
        tick();
        launch(8'd0);
        tick();
        chk("t1_pops", pops, 0);
        // 2: four words, consumer always ready, pops every other cycle
        clear_counts();
        chk_gap = 1;
        out_ready = 1;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        repeat (3) tick();
        launch(8'd4);
        run_idle(100, 0, 0);
        chk_gap = 0;
        chk("t2_pops", pops, 4);
        chk("t2_accepts", accepts, 4);
        chk("t2_lasts", lasts, 1);
        // 3: stalled consumer fills skid buffer, then drains in order
        clear_counts();
        out_ready = 0;
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        repeat (3) tick();
        launch(8'd6);
        repeat (9) tick();
        chk("t3_stall_pops", pops, 2);
        chk("t3_stall_valid", out_valid, 1);
        out_ready = 1;
        run_idle(200, 0, 0);
        chk("t3_pops", pops, 6);
        chk("t3_accepts", accepts, 6);
        // 4: FIFO runs dry mid-burst
        clear_counts();
        push(8'h51); push(8'h52);
        repeat (3) tick();
        launch(8'd5);
        repeat (20) tick();
        chk("t4_dry_pops", pops, 2);
        chk("t4_dry_busy", busy, 1);
        push(8'h53); push(8'h54); push(8'h55);
        run_idle(200, 0, 0);
        chk("t4_pops", pops, 5);
        chk("t4_accepts", accepts, 5);
        // 5: long burst with random backpressure
        clear_counts();
        for (int i = 0; i < 3; i++) push(8'($urandom));
        repeat (3) tick();
        launch(8'd200);
        run_idle(3000, 1, 1);
        chk("t5_accepts", accepts, 200);
        chk("t5_lasts", lasts, 1);
        // 6: reset mid-burst, then a fresh short burst
        clear_counts();
        out_ready = 1;
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
        repeat (3) tick();
        launch(8'd8);
        for (int n = 0; n < 100 && accepts < 3; n++) tick();
        chk("t6_pre_acc", accepts, 3);
        rst_n = 0;
        #1 check_reset();
        fq.delete();
        exp_q.delete();
        m_busy = 0;
        m_done = 0;
        prev_stall = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        clear_counts();
        push(8'h71); push(8'h72);
        repeat (3) tick();
        launch(8'd2);
        run_idle(100, 0, 0);
        chk("t6_accepts", accepts, 2);
        chk("t6_pops", pops, 2);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
